// File: rtl/uart_frame_ctrl.sv
// Frame sequencer behind uart_recv: parses SOF/CMD/LEN/payload/CSUM frames,
// streams payload bytes downstream and reports each frame as OK or errored.
module uart_frame_ctrl #(
    parameter int unsigned CLK_FREQ   = 65000000,
    parameter int unsigned TIMEOUT_US = 1000,
    parameter int unsigned MAX_LEN    = 16,
    parameter logic [7:0]  SOF_BYTE   = 8'hA5
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       busy,
    output logic [7:0] cmd,
    output logic [7:0] len,
    output logic       pld_valid,
    output logic [7:0] pld_data,
    output logic [7:0] pld_idx,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int unsigned TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rx_done_q;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    len_q, len_d;
    logic          pld_valid_q, pld_valid_d;
    logic [7:0]    pld_data_q, pld_data_d;
    logic [7:0]    pld_idx_q, pld_idx_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;

    logic byte_stb_s;
    logic timeout_s;

    // Rising edge of rx_done is the single accept point per received byte;
    // an arriving byte takes priority over an expiring timeout.
    assign byte_stb_s = rx_done & ~rx_done_q;
    assign timeout_s  = (state_q != ST_IDLE) && (tmo_q == TMO_LAST) && !byte_stb_s;

    // Next-state, checksum, counters and registered output values.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        pld_valid_d = 1'b0;
        pld_data_d  = pld_data_q;
        pld_idx_d   = pld_idx_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;

        if (byte_stb_s || (state_q == ST_IDLE) || timeout_s) begin
            tmo_d = {TW{1'b0}};
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (timeout_s) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b11;
            state_d     = ST_IDLE;
        end else if (byte_stb_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SOF_BYTE) begin
                        sum_d   = 8'h00;
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    cmd_d   = rx_data;
                    sum_d   = rx_data;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    len_d = rx_data;
                    sum_d = sum_q + rx_data;
                    if (rx_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b10;
                        state_d     = ST_IDLE;
                    end else if (rx_data == 8'h00) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d   = 8'h00;
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    pld_valid_d = 1'b1;
                    pld_data_d  = rx_data;
                    pld_idx_d   = idx_q;
                    sum_d       = sum_q + rx_data;
                    idx_d       = idx_q + 8'd1;
                    // SOF_BYTE here is plain payload; only the count ends the payload.
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_CSUM: begin
                    if (rx_data == sum_q) begin
                        frame_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'b01;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, edge detector, counters and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            rx_done_q   <= 1'b0;
            sum_q       <= 8'h00;
            idx_q       <= 8'h00;
            tmo_q       <= {TW{1'b0}};
            busy_q      <= 1'b0;
            cmd_q       <= 8'h00;
            len_q       <= 8'h00;
            pld_valid_q <= 1'b0;
            pld_data_q  <= 8'h00;
            pld_idx_q   <= 8'h00;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            rx_done_q   <= rx_done;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            pld_valid_q <= pld_valid_d;
            pld_data_q  <= pld_data_d;
            pld_idx_q   <= pld_idx_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign busy      = busy_q;
    assign cmd       = cmd_q;
    assign len       = len_q;
    assign pld_valid = pld_valid_q;
    assign pld_data  = pld_data_q;
    assign pld_idx   = pld_idx_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: frame-position model checked every cycle,
// plus directed frames with hand-computed pulse counts and values.
module tb_uart_frame_ctrl;

    localparam int unsigned CLK_FREQ   = 1000000;
    localparam int unsigned TIMEOUT_US = 1000;
    localparam int unsigned MAX_LEN    = 16;
    localparam int          T_CYC      = 1000;   // 1 MHz / 1e6 * 1000 us

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx_done   = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       busy, pld_valid, frame_ok, frame_err;
    logic [7:0] cmd, len, pld_data, pld_idx;
    logic [1:0] err_code;

    uart_frame_ctrl #(
        .CLK_FREQ(CLK_FREQ), .TIMEOUT_US(TIMEOUT_US), .MAX_LEN(MAX_LEN), .SOF_BYTE(8'hA5)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .busy(busy), .cmd(cmd), .len(len), .pld_valid(pld_valid), .pld_data(pld_data),
        .pld_idx(pld_idx), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a frame is the list of bytes accepted since SOF; each byte's role
    // follows from its position in that list.
    logic [7:0] fq[$];
    int         gap = 0;
    bit         prev_done = 1'b0;
    int         cyc = 0;
    logic       e_busy = 1'b0, e_pv = 1'b0, e_ok = 1'b0, e_err = 1'b0;
    logic [7:0] e_cmd = 8'h00, e_len = 8'h00, e_pd = 8'h00, e_pi = 8'h00;
    logic [1:0] e_code = 2'b00;

    task automatic model_byte(input logic [7:0] b);
        int pos;
        logic [7:0] s;
        if (fq.size() == 0) begin
            if (b == 8'hA5) fq.push_back(b);
        end else begin
            fq.push_back(b);
            pos = fq.size();
            if (pos == 2) begin
                e_cmd = b;
            end else if (pos == 3) begin
                e_len = b;
                if (int'(b) > int'(MAX_LEN)) begin
                    e_err = 1'b1; e_code = 2'b10; fq.delete();
                end
            end else if (pos <= 3 + int'(fq[2])) begin
                e_pv = 1'b1; e_pd = b; e_pi = 8'(pos - 4);
            end else begin
                s = 8'h00;
                for (int i = 1; i < pos - 1; i++) s = s + fq[i];
                if (b == s) begin
                    e_ok = 1'b1;
                end else begin
                    e_err = 1'b1; e_code = 2'b01;
                end
                fq.delete();
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
            e_pv = 1'b0; e_ok = 1'b0; e_err = 1'b0;
            if (!sys_rst_n) begin
                fq.delete(); gap = 0; prev_done = 1'b0;
                e_busy = 1'b0; e_cmd = 8'h00; e_len = 8'h00; e_pd = 8'h00;
                e_pi = 8'h00; e_code = 2'b00;
            end else begin
                if (rx_done && !prev_done) begin
                    gap = 0;
                    model_byte(rx_data);
                end else if (fq.size() > 0) begin
                    gap++;
                    if (gap >= T_CYC) begin
                        e_err = 1'b1; e_code = 2'b11; fq.delete();
                    end
                end
                prev_done = rx_done;
                e_busy = (fq.size() > 0);
            end
        end
    end

    // Observations of DUT pulses for the directed checks.
    int         dut_ok = 0, dut_err = 0, dut_pv = 0;
    int         err_cyc = -1, acc_cyc = 0;
    logic       busy_at_err = 1'b1;
    logic [15:0] pld_q[$];

    initial begin
        logic [37:0] act, exp;
        forever begin
            @(negedge sys_clk);
            act = {busy, cmd, len, pld_valid, pld_valid ? pld_data : 8'h00,
                   pld_valid ? pld_idx : 8'h00, frame_ok, frame_err, err_code};
            if (!sys_rst_n) begin
                act = {busy, cmd, len, pld_valid, pld_data, pld_idx, frame_ok, frame_err, err_code};
                exp = '0;
            end else begin
                exp = {e_busy, e_cmd, e_len, e_pv, e_pv ? e_pd : 8'h00,
                       e_pv ? e_pi : 8'h00, e_ok, e_err, e_code};
            end
            chk("cycle_outputs", 64'(act), 64'(exp));
            if (pld_valid) begin
                dut_pv++;
                pld_q.push_back({pld_idx, pld_data});
            end
            if (frame_ok) dut_ok++;
            if (frame_err) begin
                dut_err++; err_cyc = cyc; busy_at_err = busy;
            end
        end
    end

    logic [7:0] seq[$];

    task automatic clr();
        dut_ok = 0; dut_err = 0; dut_pv = 0; err_cyc = -1; busy_at_err = 1'b1;
        pld_q.delete();
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int gp);
        @(posedge sys_clk); #2;
        rx_data = b; rx_done = 1'b1; acc_cyc = cyc + 1;
        repeat (hold) @(posedge sys_clk);
        #2 rx_done = 1'b0;
        repeat (gp) @(posedge sys_clk);
    endtask

    task automatic send_seq(input int hold, input int gp);
        foreach (seq[i]) send(seq[i], hold, gp);
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_outputs", 64'({busy, cmd, len, pld_valid, pld_data, pld_idx,
                                  frame_ok, frame_err, err_code}), 64'd0);
        @(posedge sys_clk); #2 sys_rst_n = 1'b1;

        // Good frame; checksum covers CMD, LEN and payload: 10+02+01+02 = 15
        clr(); seq = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h15}; send_seq(1, 1);
        chk("t1_ok_cnt", 64'(dut_ok), 64'd1);
        chk("t1_err_cnt", 64'(dut_err), 64'd0);
        chk("t1_pv_cnt", 64'(dut_pv), 64'd2);
        chk("t1_pld0", 64'(pld_q.size() > 0 ? pld_q[0] : 16'hFFFF), 64'h0001);
        chk("t1_pld1", 64'(pld_q.size() > 1 ? pld_q[1] : 16'hFFFF), 64'h0102);
        chk("t1_cmd_len", 64'({cmd, len}), 64'h1002);

        // Checksum that leaves out LEN is wrong
        clr(); seq = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h13}; send_seq(1, 0);
        chk("t1b_err_code", 64'({dut_ok[7:0], dut_err[7:0], err_code}), 64'({8'd0, 8'd1, 2'b01}));

        clr(); seq = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h14}; send_seq(1, 1);
        chk("t2_counts", 64'({dut_ok[7:0], dut_err[7:0]}), 64'h0001);
        chk("t2_err_code", 64'(err_code), 64'd1);
        chk("t2_busy_at_err", 64'(busy_at_err), 64'd0);

        clr(); seq = '{8'hA5, 8'h20, 8'h11}; send_seq(1, 1);
        chk("t3_err_code", 64'({dut_err[7:0], err_code}), 64'({8'd1, 2'b10}));
        chk("t3_cmd_len_busy", 64'({cmd, len, busy}), 64'({8'h20, 8'h11, 1'b0}));

        clr(); seq = '{8'h00, 8'hFF, 8'h7E, 8'hA5, 8'h30, 8'h00, 8'h30}; send_seq(1, 2);
        chk("t4_counts", 64'({dut_ok[7:0], dut_err[7:0], dut_pv[7:0]}), 64'h010000);
        chk("t4_cmd_len", 64'({cmd, len}), 64'h3000);

        // SOF value inside the payload is data
        clr(); seq = '{8'hA5, 8'h01, 8'h01, 8'hA5, 8'hA7}; send_seq(1, 1);
        chk("t4b_sof_in_payload", 64'({dut_ok[7:0], dut_pv[7:0]}), 64'h0101);

        clr(); seq = '{8'hA5, 8'h10, 8'h03, 8'h01}; send_seq(1, 0);
        repeat (T_CYC + 100) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("t5_err_code", 64'({dut_err[7:0], err_code, busy}), 64'({8'd1, 2'b11, 1'b0}));
        chk("t5_latency", 64'(err_cyc - acc_cyc), 64'(T_CYC));

        clr(); seq = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h15}; send_seq(300, 2);
        chk("t6_held_counts", 64'({dut_ok[7:0], dut_err[7:0], dut_pv[7:0]}), 64'h010002);

        // Reset mid-payload, then the frame tail must be ignored
        clr(); seq = '{8'hA5, 8'h10, 8'h02, 8'h01}; send_seq(300, 2);
        @(posedge sys_clk); #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("t6_reset_outputs", 64'({busy, cmd, len, pld_valid, pld_data, pld_idx,
                                     frame_ok, frame_err, err_code}), 64'd0);
        repeat (2) @(posedge sys_clk); #2 sys_rst_n = 1'b1;
        clr(); seq = '{8'h02, 8'h15}; send_seq(300, 2);
        chk("t6_tail_ignored", 64'({dut_ok[7:0], dut_err[7:0], dut_pv[7:0], 7'd0, busy}), 64'd0);
        clr(); seq = '{8'hA5, 8'h40, 8'h01, 8'h09, 8'h4A}; send_seq(300, 2);
        chk("t6_fresh_frame", 64'({dut_ok[7:0], dut_pv[7:0], cmd}), 64'h010140);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
